// File: rtl/fetch_pc_gen_if.sv
// Fetch PC generator bus: predictor/decode/execute control inputs and the PC/valid pipeline outputs.
// The slave side is the PC generator; the master side is the surrounding pipeline and predictor.
interface fetch_pc_gen_if #(
  parameter int PC_W = 10
);
  logic            if_prediction;
  logic [PC_W-1:0] if_PBT;
  logic [1:0]      exe_correction;
  logic [PC_W-1:0] exe_PBT;
  logic [PC_W-1:0] exe_CNI;
  logic            bp_flush;
  logic            id_is_jump;
  logic            id_is_btype;
  logic            id_jump_in_bht;
  logic [PC_W-1:0] id_branchtarget;
  logic            exe_is_ctrl;
  logic            isr_ret;
  logic            int_req;
  logic            int_ack;
  logic            ISR_running;
  logic [PC_W-1:0] if_PC;
  logic [PC_W-1:0] id_PC;
  logic [PC_W-1:0] exe_PC;
  logic            id_valid;
  logic            exe_valid;
  logic            redirect;

  modport master (
    output if_prediction, if_PBT, exe_correction, exe_PBT, exe_CNI, bp_flush,
           id_is_jump, id_is_btype, id_jump_in_bht, id_branchtarget, exe_is_ctrl,
           isr_ret, int_req,
    input  int_ack, ISR_running, if_PC, id_PC, exe_PC, id_valid, exe_valid, redirect
  );

  modport slave (
    input  if_prediction, if_PBT, exe_correction, exe_PBT, exe_CNI, bp_flush,
           id_is_jump, id_is_btype, id_jump_in_bht, id_branchtarget, exe_is_ctrl,
           isr_ret, int_req,
    output int_ack, ISR_running, if_PC, id_PC, exe_PC, id_valid, exe_valid, redirect
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: IF PC register, next-PC selection, IF->ID->EXE PC/valid pipeline
// and the interrupt entry/return FSM.
module fetch_pc_gen #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] ISR_VECTOR = PC_W'(10'h3C0)
) (
  input  logic           CLK,
  input  logic           nrst,
  input  logic           en,
  input  logic           stall,
  fetch_pc_gen_if.slave  bus
);

  typedef enum logic {NORM, ISR} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_p0;
  logic [PC_W-1:0] pc_p1;
  logic [PC_W-1:0] pc_p2;
  logic            vld_p1;
  logic            vld_p2;
  logic [PC_W-1:0] saved_pc;
  logic            int_ack_q;
  logic            isr_running_q;

  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_next;
  logic            advance;
  logic            corr_take;
  logic            jump_take;
  logic            entry;
  logic            ret_take;
  logic            kill_id;

  // Sequential fetch address; wraps naturally at the top of the word space.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

  assign advance = en & ~stall;

  // Stage p0: next-PC selection
  always_comb begin
    pc_seq    = pc_inc(pc_p0);
    corr_take = bus.exe_correction[1];
    jump_take = ~corr_take & bus.id_is_jump & ~bus.id_jump_in_bht & vld_p1;
    // Entry is blocked while any control transfer is in flight so saved_pc is never stale.
    entry     = (state_q == NORM) & bus.int_req & ~bus.id_is_jump & ~bus.id_is_btype &
                ~bus.exe_is_ctrl & ~bus.exe_correction[1] & ~(bus.isr_ret & vld_p1);
    ret_take  = (state_q == ISR) & bus.isr_ret & vld_p1 & ~corr_take & ~jump_take;

    if (bus.exe_correction == 2'b11)      pc_next = bus.exe_PBT;
    else if (bus.exe_correction == 2'b10) pc_next = bus.exe_CNI;
    else if (jump_take)                   pc_next = bus.id_branchtarget;
    else if (entry)                       pc_next = ISR_VECTOR;
    else if (ret_take)                    pc_next = saved_pc;
    else if (bus.if_prediction)           pc_next = bus.if_PBT;
    else                                  pc_next = pc_seq;

    kill_id = bus.bp_flush | entry | corr_take | jump_take | ret_take;
  end

  assign bus.redirect = (pc_next != pc_seq);

  // Stage p0 -> p1 -> p2 registers and interrupt FSM
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state_q       <= NORM;
      pc_p0         <= RESET_PC;
      pc_p1         <= '0;
      pc_p2         <= '0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      saved_pc      <= '0;
      int_ack_q     <= 1'b0;
      isr_running_q <= 1'b0;
    end else if (advance) begin
      pc_p0     <= pc_next;
      pc_p1     <= pc_p0;
      pc_p2     <= pc_p1;
      vld_p1    <= ~kill_id;
      vld_p2    <= vld_p1 & ~bus.bp_flush;
      int_ack_q <= entry;
      case (state_q)
        NORM: begin
          if (entry) begin
            // The IF instruction is discarded and re-fetched from saved_pc on return.
            saved_pc      <= pc_p0;
            isr_running_q <= 1'b1;
            state_q       <= ISR;
          end
        end
        ISR: begin
          if (ret_take) begin
            isr_running_q <= 1'b0;
            state_q       <= NORM;
          end
        end
        default: state_q <= NORM;
      endcase
    end else begin
      int_ack_q <= 1'b0;
    end
  end

  assign bus.if_PC       = pc_p0;
  assign bus.id_PC       = pc_p1;
  assign bus.exe_PC      = pc_p2;
  assign bus.id_valid    = vld_p1;
  assign bus.exe_valid   = vld_p2;
  assign bus.int_ack     = int_ack_q;
  assign bus.ISR_running = isr_running_q;

endmodule
